// File: rtl/ppi_pkg.sv
// Shared definitions for the PPI host master: the bus-cycle state encoding,
// PPI register addresses, the default control word and a small helper that
// turns a cycle count into a down-counter load value.
package ppi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4,
        ST_INIT    = 3'd5
    } state_t;

    localparam logic [2:0] ADDR_PORTA  = 3'd0;
    localparam logic [2:0] ADDR_PORTB  = 3'd1;
    localparam logic [2:0] ADDR_PORTC  = 3'd2;
    localparam logic [2:0] ADDR_CWR    = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd7;

    localparam logic [7:0] DEFAULT_CWR = 8'h9B;

    // A timed state lasting n cycles loads n-1; zero-length states load 0.
    function automatic logic [7:0] cyc_load(input int unsigned n);
        return (n == 0) ? 8'd0 : 8'(n - 1);
    endfunction

endpackage

// File: rtl/ppi_host_master_if.sv
// Request/response channel and PPI bus signals of the host master.
// The master modport is the view of ppi_host_master itself; the slave
// modport is the view of whatever sits on the other side (controller and
// PPI model).
interface ppi_host_master_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;

    logic       rsp_valid;
    logic       rsp_write;
    logic [7:0] rsp_rdata;
    logic       busy;

    logic       rdb;
    logic       wrb;
    logic [2:0] address;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, data_in,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
        output rdb, wrb, address, data_out, data_oe
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, data_in,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
        input  rdb, wrb, address, data_out, data_oe
    );

endinterface

// File: rtl/ppi_cycle_timer.sv
// 8-bit loadable down-counter that times each phase of a PPI bus cycle.
// done is high while the count is zero; the count parks at zero.
module ppi_cycle_timer (
    input  logic       clk,
    input  logic       resetb,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;

    // Load on phase entry, otherwise count down towards zero.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd0);

endmodule

// File: rtl/ppi_host_master.sv
// Host-side PPI bus initiator. Turns valid/ready requests into timed
// SETUP / STROBE / HOLD / RECOVER bus cycles and returns a one-cycle
// response pulse carrying read data.
// Optional feature: define PPI_INIT_SEQ_EN to write INIT_CWR to the control
// word register after every reset before the first request is accepted.
module ppi_host_master
    import ppi_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 1,
    parameter logic [7:0]  INIT_CWR    = DEFAULT_CWR
) (
    input  logic               clk,
    input  logic               resetb,
    ppi_host_master_if.master  bus
);

`ifdef PPI_INIT_SEQ_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t     state;
    state_t     next_state;
    logic       tmr_load;
    logic [7:0] tmr_val;
    logic       tmr_done;
    logic       accept;
    logic       strobe_end;
    logic       cur_write;
    logic       is_init;

    ppi_cycle_timer u_timer (
        .clk      (clk),
        .resetb   (resetb),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= RESET_STATE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and timer load for the phase being entered.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = 8'd0;
        accept     = 1'b0;
        strobe_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    next_state = ST_SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = cyc_load(SETUP_CYC);
                end
            end
            ST_INIT: begin
                next_state = ST_SETUP;
                tmr_load   = 1'b1;
                tmr_val    = cyc_load(SETUP_CYC);
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    next_state = ST_STROBE;
                    tmr_load   = 1'b1;
                    tmr_val    = cyc_load(STROBE_CYC);
                end
            end
            ST_STROBE: begin
                if (tmr_done) begin
                    strobe_end = 1'b1;
                    next_state = ST_HOLD;
                    tmr_load   = 1'b1;
                    tmr_val    = cyc_load(HOLD_CYC);
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    if (RECOVER_CYC == 0) begin
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_RECOVER;
                        tmr_load   = 1'b1;
                        tmr_val    = cyc_load(RECOVER_CYC);
                    end
                end
            end
            ST_RECOVER: begin
                if (tmr_done) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state == ST_IDLE) && resetb;
    assign bus.busy      = (state != ST_IDLE);

    // Registered bus and response outputs, computed from the phase being
    // entered so strobes are glitch-free and change only on clock edges.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            bus.rdb       <= 1'b1;
            bus.wrb       <= 1'b1;
            bus.address   <= 3'd0;
            bus.data_out  <= 8'd0;
            bus.data_oe   <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_write <= 1'b0;
            bus.rsp_rdata <= 8'd0;
            cur_write     <= 1'b0;
            is_init       <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;

            if (accept) begin
                bus.address <= bus.req_addr;
                bus.data_oe <= bus.req_write;
                cur_write   <= bus.req_write;
                is_init     <= 1'b0;
                if (bus.req_write) begin
                    bus.data_out <= bus.req_wdata;
                end
            end else if (state == ST_INIT) begin
                bus.address  <= ADDR_CWR;
                bus.data_out <= INIT_CWR;
                bus.data_oe  <= 1'b1;
                cur_write    <= 1'b1;
                is_init      <= 1'b1;
            end else if (next_state == ST_RECOVER || next_state == ST_IDLE) begin
                bus.data_oe <= 1'b0;
            end

            // Only one strobe can be low: the one matching the transaction.
            bus.rdb <= !(next_state == ST_STROBE && !cur_write);
            bus.wrb <= !(next_state == ST_STROBE && cur_write);

            // Read data is sampled as the last strobe cycle ends.
            if (strobe_end && !is_init) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_write <= cur_write;
                bus.rsp_rdata <= cur_write ? 8'd0 : bus.data_in;
            end
        end
    end

endmodule

// File: tb/tb_ppi_host_master.sv
// Self-checking bench for ppi_host_master: a table of transactions against a
// default-timed instance, a parameter corner case on a second instance, and
// hand-written reset sequences. Responses are checked through a scoreboard.
module tb_ppi_host_master;
    import ppi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetb;

    ppi_host_master_if a_if ();
    ppi_host_master_if b_if ();

    ppi_host_master #(
        .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1), .RECOVER_CYC(1), .INIT_CWR(8'h9B)
    ) dut_a (
        .clk    (clk),
        .resetb (resetb),
        .bus    (a_if)
    );

    ppi_host_master #(
        .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .RECOVER_CYC(0), .INIT_CWR(8'h9B)
    ) dut_b (
        .clk    (clk),
        .resetb (resetb),
        .bus    (b_if)
    );

`ifdef PPI_INIT_SEQ_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    // Stimulus, steered to one instance by sel.
    bit         sel;
    logic       tb_valid;
    logic       tb_write;
    logic [2:0] tb_addr;
    logic [7:0] tb_wdata;
    logic [7:0] rd_val;

    // PPI model: drives rd_val while the read strobe is low, else floats high.
    always_comb begin
        a_if.req_valid = tb_valid && !sel;
        a_if.req_write = tb_write;
        a_if.req_addr  = tb_addr;
        a_if.req_wdata = tb_wdata;
        a_if.data_in   = a_if.rdb ? 8'hFF : rd_val;
        b_if.req_valid = tb_valid && sel;
        b_if.req_write = tb_write;
        b_if.req_addr  = tb_addr;
        b_if.req_wdata = tb_wdata;
        b_if.data_in   = b_if.rdb ? 8'hFF : rd_val;
    end

    // View of the selected instance.
    logic       v_ready, v_rsp_valid, v_rsp_write, v_rdb, v_wrb, v_oe, v_busy;
    logic [2:0] v_addr;
    logic [7:0] v_rdata, v_dout;

    always_comb begin
        v_ready     = sel ? b_if.req_ready : a_if.req_ready;
        v_rsp_valid = sel ? b_if.rsp_valid : a_if.rsp_valid;
        v_rsp_write = sel ? b_if.rsp_write : a_if.rsp_write;
        v_rdata     = sel ? b_if.rsp_rdata : a_if.rsp_rdata;
        v_rdb       = sel ? b_if.rdb       : a_if.rdb;
        v_wrb       = sel ? b_if.wrb       : a_if.wrb;
        v_oe        = sel ? b_if.data_oe   : a_if.data_oe;
        v_busy      = sel ? b_if.busy      : a_if.busy;
        v_addr      = sel ? b_if.address   : a_if.address;
        v_dout      = sel ? b_if.data_out  : a_if.data_out;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard of expected responses, pushed at accept time.
    typedef struct packed {
        logic       write;
        logic [7:0] rdata;
    } rsp_t;

    rsp_t       exp_q[$];
    rsp_t       mon_exp;
    logic       prev_strobe = 1'b0;
    logic [2:0] prev_addr   = 3'd0;
    logic [7:0] prev_dout   = 8'd0;

    // Response checking and bus invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (v_rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp", {v_rsp_write, v_rdata}, mon_exp);
            end
        end
        if (v_rdb === 1'b0 || v_wrb === 1'b0) begin
            check("strobe_exclusive", v_rdb | v_wrb, 1'b1);
            if (v_rdb === 1'b0) check("oe_during_read", v_oe, 1'b0);
            if (prev_strobe) check("bus_stable_in_strobe", {v_addr, v_dout}, {prev_addr, prev_dout});
        end
        prev_strobe <= (v_rdb === 1'b0 || v_wrb === 1'b0);
        prev_addr   <= v_addr;
        prev_dout   <= v_dout;
    end

    // After reset release: ready at once, or after one init write of the CWR.
    task automatic post_reset(input string nm);
`ifdef PPI_INIT_SEQ_EN
        int n     = 0;
        int n_low = 0;
        bit saw   = 1'b0;
        while (v_ready !== 1'b1 && n < 100) begin
            if (v_wrb === 1'b0) begin
                n_low++;
                if (v_addr === ADDR_CWR && v_dout === DEFAULT_CWR) saw = 1'b1;
            end
            tick();
            n++;
        end
        check({nm, "_init_write"}, saw, 1'b1);
        check({nm, "_init_strobe_cycles"}, n_low, 32'd2);
        check({nm, "_ready"}, v_ready, 1'b1);
`else
        check({nm, "_ready"}, v_ready, 1'b1);
`endif
    endtask

    // One transaction with a full per-cycle timeline check. Returns in the
    // cycle where req_ready is high again.
    task automatic run_txn(input string nm, input logic w, input logic [2:0] a,
                           input logic [7:0] d, input logic [7:0] rv,
                           input logic [7:0] exp_rd, input bit chain,
                           input int s, input int t, input int h, input int r);
        int         n         = 0;
        int         ready_cyc = 1 + s + t + h + r;
        logic [7:0] exp_v;
        logic [7:0] act_v;
        rd_val   = rv;
        tb_write = w;
        tb_addr  = a;
        tb_wdata = d;
        tb_valid = 1'b1;
        while (v_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({nm, "_accept"}, v_ready, 1'b1);
        exp_q.push_back('{write: w, rdata: exp_rd});
        tick();
        if (!chain) begin
            tb_valid = 1'b0;
            tb_write = ~w;
            tb_addr  = ~a;
            tb_wdata = ~d;
        end
        for (int k = 1; k <= ready_cyc; k++) begin
            exp_v = {a, (w && k <= s + t + h), !(!w && k > s && k <= s + t),
                     !(w && k > s && k <= s + t), (k == s + t + 1), (k == ready_cyc)};
            act_v = {v_addr, v_oe, v_rdb, v_wrb, v_rsp_valid, v_ready};
            check($sformatf("%s_cyc%0d", nm, k), act_v, exp_v);
            if (w && k == s + 1) check({nm, "_data_out"}, v_dout, d);
            if (k < ready_cyc) tick();
        end
    endtask

    typedef struct {
        logic       write;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdval;
        logic [7:0] exp_rdata;
        bit         chain;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 3'd3, 8'h80, 8'hFF, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 3'd0, 8'h00, 8'h5A, 8'h5A, 1'b0};
        vecs[2] = '{1'b1, 3'd1, 8'hA5, 8'hFF, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 3'd2, 8'h00, 8'hC3, 8'hC3, 1'b0};
        vecs[4] = '{1'b1, 3'd0, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 3'd7, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 3'd7, 8'hFF, 8'hFF, 8'h00, 1'b0};

        sel      = 1'b0;
        tb_valid = 1'b0;
        tb_write = 1'b0;
        tb_addr  = 3'd0;
        tb_wdata = 8'd0;
        rd_val   = 8'hFF;
        resetb   = 1'b0;
        repeat (2) tick();

        check("reset_state",
              {v_addr, v_dout, v_oe, v_rdb, v_wrb, v_rsp_valid, v_rsp_write, v_rdata, v_busy, v_ready},
              {3'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, INIT_EN, 1'b0});
        resetb = 1'b1;
        tick();
        post_reset("release");

        // Idle with no request: no bus activity.
        tick();
        check("idle_quiet", {v_rdb, v_wrb, v_oe, v_rsp_valid, v_busy}, 5'b11000);

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdval, vecs[i].exp_rdata, vecs[i].chain, 1, 2, 1, 1);
        end

        // Reset in the first strobe cycle of a write aborts it silently.
        tb_write = 1'b1;
        tb_addr  = 3'd1;
        tb_wdata = 8'h33;
        tb_valid = 1'b1;
        tick();
        tb_valid = 1'b0;
        tick();
        check("abort_wrb_low", v_wrb, 1'b0);
        resetb = 1'b0;
        tick();
        check("abort_released", {v_wrb, v_rdb, v_oe, v_ready, v_rsp_valid}, 5'b11000);
        resetb = 1'b1;
        tick();
        post_reset("abort");
        repeat (8) tick();

        // Stretched setup/hold, single strobe cycle, no recovery.
        sel = 1'b1;
        tick();
        run_txn("long_setup_wr", 1'b1, 3'd3, 8'h55, 8'hFF, 8'h00, 1'b0, 3, 1, 2, 0);
        run_txn("long_setup_rd", 1'b0, 3'd2, 8'h00, 8'h3C, 8'h3C, 1'b0, 3, 1, 2, 0);

        repeat (4) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
